// File: rtl/cell_fill_sequencer_if.sv
// Request and line-drawer signals of the cell fill sequencer.
// The sequencer uses the slave side; its driver (request source plus line drawer) uses master.
interface cell_fill_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_col;
    logic [4:0]  req_row;
    logic [2:0]  req_color;
    logic        ld_start;
    logic [10:0] ld_x0;
    logic [10:0] ld_y0;
    logic [10:0] ld_x1;
    logic [10:0] ld_y1;
    logic        ld_drawn;
    logic        line_active;
    logic [2:0]  pix_color;
    logic        cell_done;
    logic        req_err;

    modport master (
        output req_valid, req_col, req_row, req_color, ld_drawn,
        input  req_ready, ld_start, ld_x0, ld_y0, ld_x1, ld_y1,
        input  line_active, pix_color, cell_done, req_err
    );

    modport slave (
        input  req_valid, req_col, req_row, req_color, ld_drawn,
        output req_ready, ld_start, ld_x0, ld_y0, ld_x1, ld_y1,
        output line_active, pix_color, cell_done, req_err
    );
endinterface

// File: rtl/cell_fill_sequencer.sv
// Breaks one grid-cell paint request into CELL_SIZE horizontal lines and feeds
// them to the line drawer one at a time, waiting for each drawn pulse.
module cell_fill_sequencer #(
    parameter int CELL_SIZE = 20,
    parameter int ORIGIN_X  = 220,
    parameter int ORIGIN_Y  = 0,
    parameter int COLS      = 10,
    parameter int ROWS      = 24,
    parameter int TIMEOUT   = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    cell_fill_sequencer_if.slave bus
);
    localparam int LW = $clog2(CELL_SIZE);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [10:0] OX = 11'(ORIGIN_X);
    localparam logic [10:0] OY = 11'(ORIGIN_Y);
    localparam logic [10:0] CS = 11'(CELL_SIZE);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, NEXT, DONE} state_e;

    state_e        state_q, state_d;
    logic [3:0]    col_q, col_d;
    logic [4:0]    row_q, row_d;
    logic [2:0]    color_q, color_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [10:0]   x0_q, x0_d, x1_q, x1_d, y_q, y_d;
    logic [2:0]    pix_q, pix_d;
    logic          ready_q, ready_d, start_q, start_d, active_q, active_d;
    logic          done_q, done_d, err_q, err_d;
    logic [10:0]   bx, by;
    logic [CW-1:0] cnt_inc;

    assign bx      = OX + 11'(col_q) * CS;
    assign by      = OY + 11'(row_q) * CS;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        color_d = color_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y_d     = y_q;
        pix_d   = pix_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                col_d   = bus.req_col;
                row_d   = bus.req_row;
                color_d = bus.req_color;
                // Legality is judged at the transfer so the error pulse lands in LOAD.
                err_d   = (int'(bus.req_col) >= COLS) || (int'(bus.req_row) >= ROWS);
                state_d = LOAD;
            end
            LOAD: if (err_q) begin
                state_d = IDLE;
            end else begin
                x0_d    = bx;
                x1_d    = bx + CS - 11'd1;
                y_d     = by;
                pix_d   = color_q;
                idx_d   = '0;
                state_d = START;
            end
            START: state_d = WAIT;
            WAIT: if (bus.ld_drawn) begin
                cnt_d   = '0;
                state_d = NEXT;
            end else if (cnt_inc == CW'(TIMEOUT - 1)) begin
                cnt_d   = '0;
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_inc;
            end
            NEXT: if (idx_q == LW'(CELL_SIZE - 1)) begin
                state_d = DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                y_d     = y_q + 11'd1;
                state_d = START;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status outputs are registered decodes of the next state.
        ready_d  = (state_d == IDLE);
        start_d  = (state_d == START);
        active_d = (state_d == WAIT);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            color_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            x0_q     <= '0;
            x1_q     <= '0;
            y_q      <= '0;
            pix_q    <= '0;
            ready_q  <= 1'b1;
            start_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            color_q  <= color_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            x0_q     <= x0_d;
            x1_q     <= x1_d;
            y_q      <= y_d;
            pix_q    <= pix_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
            active_q <= active_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.ld_start    = start_q;
    assign bus.ld_x0       = x0_q;
    assign bus.ld_x1       = x1_q;
    assign bus.ld_y0       = y_q;
    assign bus.ld_y1       = y_q;
    assign bus.line_active = active_q;
    assign bus.pix_color   = pix_q;
    assign bus.cell_done   = done_q;
    assign bus.req_err     = err_q;
endmodule

// File: tb/tb_cell_fill_sequencer.sv
// Cycle-level check of cell_fill_sequencer against a per-cell line list model,
// with the line drawer emulated inline.
module tb_cell_fill_sequencer;
    localparam int CS = 20;
    localparam int OX = 220;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    cell_fill_sequencer_if bus ();

    cell_fill_sequencer #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, 32'(bus.req_ready), 1);
        chk({tag, "_start"}, 32'(bus.ld_start), 0);
        chk({tag, "_act"}, 32'(bus.line_active), 0);
        chk({tag, "_done"}, 32'(bus.cell_done), 0);
        chk({tag, "_err"}, 32'(bus.req_err), 0);
        chk({tag, "_x0"}, 32'(bus.ld_x0), 0);
        chk({tag, "_x1"}, 32'(bus.ld_x1), 0);
        chk({tag, "_y0"}, 32'(bus.ld_y0), 0);
        chk({tag, "_y1"}, 32'(bus.ld_y1), 0);
        chk({tag, "_pix"}, 32'(bus.pix_color), 0);
    endtask

    // Called at a negedge; returns at the negedge of the LOAD cycle.
    task automatic send(input int col, input int row, input int color, input bit hold);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_col   = 4'(col);
        bus.req_row   = 5'(row);
        bus.req_color = 3'(color);
        while (!bus.req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("xfer_timeout", 32'(bus.req_ready), 1);
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    // Runs from the LOAD negedge to the following IDLE negedge.
    // lat = cycles from ld_start to drawn (0: drawer never answers); rst_line = line to reset mid-WAIT.
    task automatic do_cell(input int col, input int row, input int color, input int lat,
                           input int rst_line, input bit spur);
        int  bx, by;
        bit  legal;
        legal = (col < 10) && (row < 24);
        chk("load_err", 32'(bus.req_err), legal ? 0 : 1);
        chk("load_start", 32'(bus.ld_start), 0);
        chk("load_rdy", 32'(bus.req_ready), 0);
        if (!legal) begin
            @(negedge clk);
            chk("bad_err_clr", 32'(bus.req_err), 0);
            chk("bad_rdy", 32'(bus.req_ready), 1);
            chk("bad_nostart", 32'(bus.ld_start), 0);
            return;
        end
        bx = (OX + col * CS) % 2048;
        by = (row * CS) % 2048;
        for (int i = 0; i < CS; i++) begin
            @(negedge clk);
            chk("st_start", 32'(bus.ld_start), 1);
            chk("st_x0", 32'(bus.ld_x0), bx);
            chk("st_x1", 32'(bus.ld_x1), (bx + CS - 1) % 2048);
            chk("st_y0", 32'(bus.ld_y0), (by + i) % 2048);
            chk("st_y1", 32'(bus.ld_y1), (by + i) % 2048);
            chk("st_pix", 32'(bus.pix_color), color);
            chk("st_act", 32'(bus.line_active), 0);
            if (spur) bus.ld_drawn = 1'b1;
            if (lat == 0) begin
                for (int k = 1; k < TO; k++) begin
                    @(negedge clk);
                    bus.ld_drawn = 1'b0;
                    chk("to_act", 32'(bus.line_active), 1);
                    chk("to_err", 32'(bus.req_err), 0);
                end
                @(negedge clk);
                chk("to_err_pulse", 32'(bus.req_err), 1);
                chk("to_act_drop", 32'(bus.line_active), 0);
                chk("to_rdy", 32'(bus.req_ready), 1);
                chk("to_nodone", 32'(bus.cell_done), 0);
                @(negedge clk);
                chk("to_err_clr", 32'(bus.req_err), 0);
                chk("to_nodone2", 32'(bus.cell_done), 0);
                return;
            end
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                bus.ld_drawn = (k == lat);
                chk("w_act", 32'(bus.line_active), 1);
                chk("w_start", 32'(bus.ld_start), 0);
                chk("w_y0", 32'(bus.ld_y0), (by + i) % 2048);
                chk("w_x1", 32'(bus.ld_x1), (bx + CS - 1) % 2048);
                if (i == rst_line && k == 2) begin
                    bus.ld_drawn = 1'b0;
                    #2 rst_n = 1'b0;
                    #1 chk_reset_vals("async_rst");
                    @(negedge clk);
                    rst_n = 1'b1;
                    repeat (30) begin
                        @(negedge clk);
                        chk("post_rst_done", 32'(bus.cell_done), 0);
                        chk("post_rst_rdy", 32'(bus.req_ready), 1);
                        chk("post_rst_start", 32'(bus.ld_start), 0);
                    end
                    return;
                end
            end
            @(negedge clk);
            bus.ld_drawn = 1'b0;
            chk("nx_act", 32'(bus.line_active), 0);
            chk("nx_start", 32'(bus.ld_start), 0);
            chk("nx_done", 32'(bus.cell_done), 0);
        end
        @(negedge clk);
        chk("cell_done", 32'(bus.cell_done), 1);
        chk("done_rdy", 32'(bus.req_ready), 0);
        @(negedge clk);
        chk("done_clr", 32'(bus.cell_done), 0);
        chk("idle_rdy", 32'(bus.req_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, r, col, lat;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_col   = '0;
        bus.req_row   = '0;
        bus.req_color = '0;
        bus.ld_drawn  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Stray drawn pulse while idle must not start anything.
        bus.ld_drawn = 1'b1;
        @(negedge clk);
        bus.ld_drawn = 1'b0;
        chk("idle_spur_start", 32'(bus.ld_start), 0);
        chk("idle_spur_rdy", 32'(bus.req_ready), 1);
        @(negedge clk);
        chk("idle_spur_start2", 32'(bus.ld_start), 0);

        send(3, 5, 6, 1'b0);
        do_cell(3, 5, 6, 5, -1, 1'b0);

        send(10, 0, 2, 1'b0);
        do_cell(10, 0, 2, 5, -1, 1'b0);

        send(1, 1, 3, 1'b0);
        do_cell(1, 1, 3, 0, -1, 1'b0);
        send(2, 2, 4, 1'b0);
        do_cell(2, 2, 4, 3, -1, 1'b0);

        // Back-to-back: second request waits on req_valid through the whole first cell.
        send(0, 0, 1, 1'b1);
        bus.req_col   = 4'd9;
        bus.req_row   = 5'd23;
        bus.req_color = 3'd5;
        do_cell(0, 0, 1, 4, -1, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        do_cell(9, 23, 5, 2, -1, 1'b0);

        for (int n = 0; n < 10; n++) begin
            c   = $urandom_range(0, 15);
            r   = $urandom_range(0, 31);
            col = $urandom_range(0, 7);
            lat = $urandom_range(1, 8);
            send(c, r, col, 1'b0);
            do_cell(c, r, col, lat, -1, n[0]);
        end

        send(4, 7, 1, 1'b0);
        do_cell(4, 7, 1, 5, 7, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
